// File: rtl/ram_seq_ctrl.sv
// Display RAM sequencer: edge-detected front-panel requests become
// address steps, auto-scan steps, single writes and a full clear sweep.
module ram_seq_ctrl #(
    parameter int          ADDR_W   = 8,
    parameter int          SCAN_DIV = 250,
    parameter logic [7:0]  FILL_HI  = 8'hFF,
    parameter bit          AUTO_INC = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              step_req,
    input  logic              wr_req,
    input  logic              clr_req,
    input  logic              mode_auto,
    input  logic [7:0]        din,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [15:0]       ram_din,
    output logic              busy
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [ADDR_W-1:0] WR_INC   = ADDR_W'(AUTO_INC ? 1 : 0);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        WR,
        CLEAR
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [15:0]       din_q, din_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              step_q, wr_q, clr_q;
    logic              step_evt, wr_evt, clr_evt;

    assign step_evt = step_req & ~step_q;
    assign wr_evt   = wr_req & ~wr_q;
    assign clr_evt  = clr_req & ~clr_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        din_d   = din_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (!mode_auto) begin
                    cnt_d = '0;
                end
                if (clr_evt) begin
                    addr_d  = '0;
                    we_d    = 1'b1;
                    din_d   = {FILL_HI, 8'h00};
                    busy_d  = 1'b1;
                    state_d = CLEAR;
                end else if (wr_evt) begin
                    we_d    = 1'b1;
                    din_d   = {FILL_HI, din};
                    busy_d  = 1'b1;
                    state_d = WR;
                end else if (step_evt) begin
                    addr_d = addr_q + ADDR_ONE;
                    cnt_d  = '0;
                end else if (mode_auto && tick) begin
                    if (cnt_q == CNT_LAST) begin
                        addr_d = addr_q + ADDR_ONE;
                        cnt_d  = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            WR: begin
                we_d    = 1'b0;
                busy_d  = 1'b0;
                addr_d  = addr_q + WR_INC;
                state_d = IDLE;
            end
            CLEAR: begin
                // Last address written this cycle: close the sweep.
                if (addr_q == ADDR_MAX) begin
                    we_d    = 1'b0;
                    addr_d  = '0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    addr_d = addr_q + ADDR_ONE;
                end
            end
            default: begin
                we_d    = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            din_q   <= 16'h0000;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            step_q  <= 1'b0;
            wr_q    <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            din_q   <= din_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            step_q  <= step_req;
            wr_q    <= wr_req;
            clr_q   <= clr_req;
        end
    end

    assign ram_addr = addr_q;
    assign ram_we   = we_q;
    assign ram_din  = din_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_ram_seq_ctrl.sv
// Scoreboard bench for ram_seq_ctrl: reference model predicts RAM
// writes and control outputs, a negedge monitor checks the DUT.
module tb_ram_seq_ctrl;

    localparam int DEPTH    = 256;
    localparam int SCAN_DIV = 4;
    localparam int FILL     = 8'hFF;
    localparam int AUTO_INC = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       step_req = 1'b0;
    logic       wr_req = 1'b0;
    logic       clr_req = 1'b0;
    logic       mode_auto = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] ram_addr;
    logic       ram_we;
    logic [15:0] ram_din;
    logic       busy;

    ram_seq_ctrl #(
        .ADDR_W(8),
        .SCAN_DIV(SCAN_DIV),
        .FILL_HI(8'hFF),
        .AUTO_INC(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .tick(tick),
        .step_req(step_req),
        .wr_req(wr_req),
        .clr_req(clr_req),
        .mode_auto(mode_auto),
        .din(din),
        .ram_addr(ram_addr),
        .ram_we(ram_we),
        .ram_din(ram_din),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int wr_seen = 0;

    typedef struct {
        int addr;
        int data;
    } wr_t;
    wr_t exp_q[$];
    wr_t got;

    // Reference model: mode flags plus a remaining-write counter
    int m_addr, m_din, m_cnt, clear_left;
    bit m_we, m_busy, in_wr, clearing;
    bit p_step, p_wr, p_clr;
    bit se, we_e, ce;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_addr = 0; m_din = 0; m_cnt = 0; clear_left = 0;
            m_we = 0; m_busy = 0; in_wr = 0; clearing = 0;
            p_step = 0; p_wr = 0; p_clr = 0;
            exp_q.delete();
        end else begin
            se   = step_req && !p_step;
            we_e = wr_req && !p_wr;
            ce   = clr_req && !p_clr;
            p_step = step_req; p_wr = wr_req; p_clr = clr_req;
            if (clearing) begin
                if (clear_left == 0) begin
                    clearing = 0; m_we = 0; m_addr = 0; m_busy = 0;
                end else begin
                    clear_left--;
                    m_addr = (m_addr + 1) % DEPTH;
                end
            end else if (in_wr) begin
                in_wr = 0; m_we = 0; m_busy = 0;
                m_addr = (m_addr + AUTO_INC) % DEPTH;
            end else begin
                if (!mode_auto) m_cnt = 0;
                if (ce) begin
                    clearing = 1; clear_left = DEPTH - 1;
                    m_addr = 0; m_we = 1; m_busy = 1;
                    m_din = FILL * 256;
                end else if (we_e) begin
                    in_wr = 1; m_we = 1; m_busy = 1;
                    m_din = FILL * 256 + int'(din);
                end else if (se) begin
                    m_addr = (m_addr + 1) % DEPTH;
                    m_cnt = 0;
                end else if (mode_auto && tick) begin
                    m_cnt++;
                    if (m_cnt == SCAN_DIV) begin
                        m_cnt = 0;
                        m_addr = (m_addr + 1) % DEPTH;
                    end
                end
            end
            if (m_we) exp_q.push_back('{m_addr, m_din});
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            checks++;
            if (ram_addr !== 8'(m_addr) || ram_we !== m_we ||
                busy !== m_busy) begin
                errors++;
                $display("FAIL ctrl t=%0t addr=%h we=%b busy=%b want %h %b %b",
                         $time, ram_addr, ram_we, busy,
                         8'(m_addr), m_we, m_busy);
            end
            if (ram_we === 1'b1) begin
                wr_seen++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL write t=%0t unexpected addr=%h data=%h",
                             $time, ram_addr, ram_din);
                end else begin
                    got = exp_q.pop_front();
                    if (ram_addr !== 8'(got.addr) ||
                        ram_din !== 16'(got.data)) begin
                        errors++;
                        $display("FAIL write t=%0t addr=%h data=%h want %h %h",
                                 $time, ram_addr, ram_din,
                                 8'(got.addr), 16'(got.data));
                    end
                end
            end
        end
    end

    int tcount = 0;
    bit tick_en = 0;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            tcount++;
            tick = tick_en && (tcount % 10 == 0);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic pulse_step();
        step_req = 1'b1;
        cyc(1);
        step_req = 1'b0;
        cyc(1);
    endtask

    task automatic wait_change(output int n);
        logic [7:0] a0;
        a0 = ram_addr;
        n = 0;
        while (ram_addr == a0 && n < 200) begin
            cyc(1);
            n++;
        end
    endtask

    int n, w0, a0;

    initial begin
        // Reset with random inputs
        repeat (10) begin
            @(posedge clk);
            #1;
            step_req = 1'($urandom); wr_req = 1'($urandom);
            clr_req = 1'($urandom); mode_auto = 1'($urandom);
            tick = 1'($urandom); din = 8'($urandom);
        end
        chk("rst_addr", int'(ram_addr), 0);
        chk("rst_we", int'(ram_we), 0);
        chk("rst_din", int'(ram_din), 0);
        chk("rst_busy", int'(busy), 0);
        step_req = 0; wr_req = 0; clr_req = 0;
        mode_auto = 0; tick = 0; din = 0;
        cyc(1);
        reset = 1'b1;
        cyc(100);
        chk("idle_addr", int'(ram_addr), 0);
        chk("idle_we", int'(ram_we), 0);
        chk("idle_din", int'(ram_din), 0);

        // Single write at address 5
        repeat (5) pulse_step();
        chk("addr5", int'(ram_addr), 5);
        din = 8'h3C;
        w0 = wr_seen;
        wr_req = 1'b1;
        cyc(1);
        chk("wr_we", int'(ram_we), 1);
        chk("wr_addr", int'(ram_addr), 5);
        chk("wr_data", int'(ram_din), 16'hFF3C);
        cyc(19);
        chk("wr_count", wr_seen - w0, 1);
        chk("wr_inc", int'(ram_addr), 6);
        wr_req = 1'b0;
        cyc(2);

        // Step to FE, then wrap
        repeat (248) pulse_step();
        chk("addr_fe", int'(ram_addr), 8'hFE);
        pulse_step();
        chk("wrap_ff", int'(ram_addr), 8'hFF);
        pulse_step();
        chk("wrap_00", int'(ram_addr), 8'h00);
        pulse_step();
        chk("wrap_01", int'(ram_addr), 8'h01);
        step_req = 1'b1;
        cyc(50);
        step_req = 1'b0;
        cyc(2);
        chk("held_step", int'(ram_addr), 8'h02);

        // Auto-scan
        mode_auto = 1'b1;
        tick_en = 1'b1;
        wait_change(n);
        wait_change(n);
        chk("scan_period", n, 40);
        mode_auto = 1'b0;
        cyc(10);
        mode_auto = 1'b1;
        wait_change(n);
        wait_change(n);
        chk("scan_restart", n, 40);
        mode_auto = 1'b0;
        tick_en = 1'b0;
        tick = 1'b0;
        cyc(3);

        // Clear sweep with a write request in the middle
        w0 = wr_seen;
        clr_req = 1'b1;
        cyc(1);
        n = 0;
        while (ram_we && n < 400) begin
            if (n == 100) wr_req = 1'b1;
            if (n == 101) wr_req = 1'b0;
            cyc(1);
            n++;
        end
        chk("clr_len", n, 256);
        chk("clr_addr", int'(ram_addr), 0);
        chk("clr_busy", int'(busy), 0);
        cyc(5);
        chk("clr_writes", wr_seen - w0, 256);
        clr_req = 1'b0;
        cyc(2);

        // Write beats step in the same cycle
        repeat (3) pulse_step();
        a0 = int'(ram_addr);
        wr_req = 1'b1;
        step_req = 1'b1;
        cyc(1);
        chk("pri_we", int'(ram_we), 1);
        chk("pri_addr", int'(ram_addr), a0);
        cyc(2);
        chk("pri_after", int'(ram_addr), (a0 + 1) % DEPTH);
        wr_req = 1'b0;
        step_req = 1'b0;
        cyc(2);

        // Reset in the middle of a clear
        clr_req = 1'b1;
        cyc(50);
        reset = 1'b0;
        #1;
        chk("midrst_we", int'(ram_we), 0);
        chk("midrst_busy", int'(busy), 0);
        clr_req = 1'b0;
        cyc(3);
        reset = 1'b1;
        w0 = wr_seen;
        cyc(20);
        chk("midrst_nowr", wr_seen - w0, 0);
        chk("midrst_addr", int'(ram_addr), 0);

        // Random traffic
        repeat (3000) begin
            @(posedge clk);
            #1;
            step_req = ($urandom_range(0, 9) == 0) ? ~step_req : step_req;
            wr_req = ($urandom_range(0, 19) == 0) ? ~wr_req : wr_req;
            clr_req = ($urandom_range(0, 399) == 0) ? ~clr_req : clr_req;
            if ($urandom_range(0, 99) == 0) mode_auto = ~mode_auto;
            tick = ($urandom_range(0, 4) == 0);
            din = 8'($urandom);
        end
        step_req = 0; wr_req = 0; clr_req = 0;
        mode_auto = 0; tick = 0;
        cyc(300);
        chk("drain", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_seq_ctrl.md
Name: ram_seq_ctrl

Overview:
Sequencing controller for the 256x16 single-port display RAM. It turns debounced front-panel requests into RAM cycles: manual address step, timed auto-scan, single-cycle byte write, and a full-memory clear sweep. It sits between the debounce/500 Hz clock logic and the RAM. It drives the RAM address, write-enable and write data, replacing the free-running address sequencer.

Parameters:
ADDR_W, 8, RAM address width; depth = 2^ADDR_W
SCAN_DIV, 250, number of tick pulses per auto-scan address step (>=1)
FILL_HI, 8'hFF, upper byte written on every write and clear cycle
AUTO_INC, 1, 1 = address increments after a manual write; 0 = address holds

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
tick  in  1  one-clk-wide enable pulse at 500 Hz
step_req  in  1  debounced address-step level (may stay high many cycles)
wr_req  in  1  debounced write level
clr_req  in  1  debounced clear level
mode_auto  in  1  1 = auto-scan enabled
din  in  8  switch data for the lower byte
ram_addr  out  ADDR_W  RAM address, registered
ram_we  out  1  RAM write enable, registered, active-high
ram_din  out  16  RAM write data, registered
busy  out  1  high while in state WR or CLEAR

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; ram_addr=0; ram_we=0; ram_din=16'h0000; busy=0.
  - scan_cnt=0; edge-detect history registers=0.
- Edge detect:
  - step_evt, wr_evt and clr_evt = req & ~req_q, where req_q is the previous-cycle sample.
  - One event per rising edge, regardless of how long the request is held.
  - Each event is valid for exactly one cycle and is acted on in the same cycle it is detected.
- States: IDLE, WR, CLEAR.
- IDLE, evaluated in priority order:
  - clr_evt: ram_addr<=0, ram_we<=1, ram_din<={FILL_HI,8'h00}, busy<=1, go to CLEAR.
  - else wr_evt: ram_we<=1, ram_din<={FILL_HI,din}, busy<=1, go to WR. ram_addr holds.
  - else step_evt: ram_addr<=ram_addr+1, scan_cnt<=0.
  - else mode_auto & tick & scan_cnt==SCAN_DIV-1: ram_addr<=ram_addr+1, scan_cnt<=0.
  - else mode_auto & tick: scan_cnt<=scan_cnt+1.
  - mode_auto=0 forces scan_cnt<=0.
  - Lower-priority events arriving in the same cycle are dropped, not queued.
- WR:
  - Exactly one cycle with ram_we=1.
  - Next edge: ram_we<=0, busy<=0, ram_addr<=ram_addr+AUTO_INC, go to IDLE.
- CLEAR:
  - ram_we stays 1 and ram_din={FILL_HI,8'h00}.
  - ram_addr increments each cycle from 0 to 2^ADDR_W-1.
  - On the cycle after address 2^ADDR_W-1 is written: ram_we<=0, ram_addr<=0, busy<=0, go to IDLE.
  - ram_we is high for exactly 2^ADDR_W consecutive cycles.
  - All events and ticks are ignored during CLEAR; scan_cnt holds.
  - The edge-detect history still updates, so a request held across the end of CLEAR does not fire again.
- Address arithmetic: modulo 2^ADDR_W; 2^ADDR_W-1 increments to 0 silently.
- ram_addr and ram_din are stable for every cycle that ram_we=1.
- Reset asserted mid-WR or mid-CLEAR: ram_we drops to 0 asynchronously. No further writes occur; partial clear contents are left as-is.
- Latency: request rising edge to ram_we=1 is 1 clk (registered output after same-cycle detect).

Test Plan:
- Reset: hold reset=0 with random inputs -> ram_addr=0, ram_we=0, ram_din=0, busy=0; after release with all requests 0, outputs stay unchanged for 100 cycles.
- Write: ram_addr=5, din=8'h3C, raise wr_req for 20 cycles -> ram_we=1 for exactly 1 cycle with ram_addr=5 and ram_din=16'hFF3C. ram_addr=6 afterwards with AUTO_INC=1; ram_addr stays 5 with AUTO_INC=0.
- Step and wrap: ram_addr=8'hFE, three separate step_req pulses -> ram_addr goes FF, 00, 01. A step_req held high for 50 cycles advances ram_addr by exactly 1.
- Auto-scan: SCAN_DIV=4, mode_auto=1, tick every 10 clk -> ram_addr increments every 40 clk. Dropping mode_auto for one tick restarts the count from 0.
- Clear: raise clr_req -> 256 consecutive cycles with ram_we=1, ram_addr 0..255, ram_din=16'hFF00; then ram_we=0, ram_addr=0, busy=0. A wr_req pulse at cycle 100 of the sweep is ignored.
- Priority and mid-op reset: wr_req and step_req rising in the same cycle -> write occurs and no step. Assert reset at cycle 50 of CLEAR -> ram_we=0 immediately, state IDLE, no further writes.
